// File: rtl/pipe_field.sv
// pipe_field: scrolling pipe obstacles, bird collision detect and score keeping.
// Two pipes scroll left and recycle forever; new gap heights come from an LFSR.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high; wins over everything
//   i_bird_y     bird top y from the physics block
//   i_alive      game running flag from the physics block
//   o_pipe0_x    pipe 0 right-edge x (left edge = x - PIPE_W)
//   o_pipe0_gap  pipe 0 gap top y
//   o_pipe1_x    pipe 1 right-edge x
//   o_pipe1_gap  pipe 1 gap top y
//   o_collision  sticky hit flag (set the cycle after a hit, cleared by reset)
//   o_score      pipes passed, saturating at 999
module pipe_field #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned PIPE_W    = 52,
    parameter int unsigned GAP_H     = 120,
    parameter int unsigned GAP_MIN   = 40,
    parameter int unsigned BIRD_X    = 100,
    parameter int unsigned BIRD_W    = 24,
    parameter int unsigned BIRD_H    = 24,
    parameter int unsigned SCROLL    = 2,
    parameter int unsigned TICK_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  i_bird_y,
    input  logic        i_alive,
    output logic [10:0] o_pipe0_x,
    output logic [9:0]  o_pipe0_gap,
    output logic [10:0] o_pipe1_x,
    output logic [9:0]  o_pipe1_gap,
    output logic        o_collision,
    output logic [9:0]  o_score
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned SW = 10;
    localparam int unsigned LW = 16;
    localparam int unsigned NP = 2;

    localparam logic [XW-1:0] X_SPAWN  = XW'(SCREEN_W + PIPE_W);
    localparam logic [XW-1:0] X_SPACE  = XW'((SCREEN_W + PIPE_W) / 2);
    localparam logic [XW-1:0] X_SCROLL = XW'(SCROLL);
    localparam logic [XW-1:0] X_BIRD   = XW'(BIRD_X);
    localparam logic [XW-1:0] X_HIT_HI = XW'(BIRD_X + BIRD_W + PIPE_W);
    localparam logic [XW-1:0] Y_BIRD_H = XW'(BIRD_H);
    localparam logic [XW-1:0] Y_GAP_H  = XW'(GAP_H);
    localparam logic [YW-1:0] GAP_BASE = YW'(GAP_MIN);
    localparam logic [YW-1:0] GAP_RST  = YW'(200);
    localparam logic [SW-1:0] SCORE_MX = SW'(999);
    localparam logic [LW-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LW-1:0] LFSR_TAPS = 16'hB400;

    logic [TICK_BITS-1:0] r_tick_cnt;
    logic [LW-1:0]        r_lfsr;
    logic [XW-1:0]        r_x   [NP];
    logic [YW-1:0]        r_gap [NP];
    logic                 r_collision;
    logic [SW-1:0]        r_score;

    logic [XW-1:0]        w_x_nxt   [NP];
    logic [YW-1:0]        w_gap_nxt [NP];
    logic [NP-1:0]        w_overlap;
    logic [NP-1:0]        w_vert;
    logic                 w_cross;
    logic                 w_hit;
    logic                 w_tick;
    logic                 w_gate;
    logic [LW-1:0]        w_lfsr_nxt;

    // Scroll tick once per counter wrap; pipes only move while playing and unhurt
    assign w_tick = &r_tick_cnt;
    assign w_gate = w_tick & i_alive & ~r_collision;

    // Right-shifting Galois LFSR
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    // Per-pipe next position/gap, score crossing and collision terms
    always_comb begin
        w_cross = 1'b0;
        w_hit   = 1'b0;
        for (int i = 0; i < NP; i++) begin
            w_x_nxt[i]   = r_x[i];
            w_gap_nxt[i] = r_gap[i];
            w_overlap[i] = 1'b0;
            w_vert[i]    = 1'b0;
            if (r_x[i] <= X_SCROLL) begin
                w_x_nxt[i]   = X_SPAWN;
                w_gap_nxt[i] = GAP_BASE + YW'(r_lfsr[7:0]);
            end else begin
                w_x_nxt[i] = r_x[i] - X_SCROLL;
            end
            if ((r_x[i] > X_BIRD) && (w_x_nxt[i] <= X_BIRD)) begin
                w_cross = 1'b1;
            end
            w_overlap[i] = (r_x[i] > X_BIRD) && (r_x[i] < X_HIT_HI);
            // 11-bit sums so the bottom-edge compare cannot wrap
            w_vert[i] = (XW'(i_bird_y) < XW'(r_gap[i])) ||
                        ((XW'(i_bird_y) + Y_BIRD_H) > (XW'(r_gap[i]) + Y_GAP_H));
            if (w_overlap[i] && w_vert[i]) begin
                w_hit = i_alive;
            end
        end
    end

    // State update; score uses the pre-update collision value via w_gate
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_lfsr      <= LFSR_SEED;
            r_x[0]      <= X_SPAWN;
            r_x[1]      <= X_SPAWN + X_SPACE;
            r_gap[0]    <= GAP_RST;
            r_gap[1]    <= GAP_RST;
            r_collision <= 1'b0;
            r_score     <= '0;
        end else begin
            r_tick_cnt  <= r_tick_cnt + TICK_BITS'(1);
            r_lfsr      <= w_lfsr_nxt;
            r_collision <= r_collision | w_hit;
            if (w_gate) begin
                for (int i = 0; i < NP; i++) begin
                    r_x[i]   <= w_x_nxt[i];
                    r_gap[i] <= w_gap_nxt[i];
                end
                if (w_cross && (r_score != SCORE_MX)) begin
                    r_score <= r_score + SW'(1);
                end
            end
        end
    end

    assign o_pipe0_x   = r_x[0];
    assign o_pipe0_gap = r_gap[0];
    assign o_pipe1_x   = r_x[1];
    assign o_pipe1_gap = r_gap[1];
    assign o_collision = r_collision;
    assign o_score     = r_score;

endmodule
